// File: rtl/math_pkg.sv
// Constants and state encoding shared by the math datapath blocks
// (adder, serial subtractor, calculator FSM).
package math_pkg;

  localparam int unsigned MATH_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/math_subtractor_serial_if.sv
// Start/busy/done handshake and operand/result bus for the serial subtractor.
interface math_subtractor_serial_if
  import math_pkg::*;
#(
  parameter int unsigned WIDTH = MATH_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff
  );

endinterface

// File: rtl/math_subtractor_fullSubtractor.sv
// Combinational 1-bit full subtractor: diff = a - b - bin, bout = borrow out.
module math_subtractor_fullSubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/math_subtractor_serial.sv
// Bit-serial subtractor: a - b - bin computed LSB first, one bit per clock,
// through a single full-subtractor cell and a borrow flop.
module math_subtractor_serial
  import math_pkg::*;
#(
  parameter int unsigned WIDTH = MATH_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  math_subtractor_serial_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state;
  state_e             state_n;
  logic               load;
  logic               step;
  logic               last;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;

  logic               cell_d;
  logic               cell_bout;

  logic               busy_q;
  logic               done_q;
  logic [WIDTH:0]     diff_q;

  math_subtractor_fullSubtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .diff (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last    = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Final bit is folded straight into diff so the result lands with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
    end else begin
      busy_q <= (state_n == S_RUN);
      done_q <= (state_n == S_DONE);
      if (load) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        borrow <= bus.bin;
        res    <= '0;
        cnt    <= '0;
      end
      if (step) begin
        a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
        res    <= {cell_d, res[WIDTH-1:1]};
        borrow <= cell_bout;
        cnt    <= cnt + CNT_W'(1);
      end
      if (last) begin
        diff_q <= {cell_bout, cell_d, res[WIDTH-1:1]};
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;

endmodule
